// File: rtl/queue_stop_dispatcher.sv
// Stop-queue read-side dispatcher: reads head/next from the queue RAM, drives the car,
// pops the head on arrival and dwells with the door open. Optional macro REPLAN_EN.
module queue_stop_dispatcher #(
  parameter int DOOR_CYCLES = 50,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             enable,
  input  logic [3:0]       andar_atual,
  input  logic [3:0]       q,
  output logic [3:0]       addr,
  output logic             shift,
  output logic [3:0]       destino,
  output logic [3:0]       proximo,
  output logic             destino_valido,
  output logic             subir,
  output logic             descer,
  output logic             porta_aberta,
  output logic [CNT_W-1:0] atendidos
);

  localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [DW-1:0] DOOR_LAST = DW'(DOOR_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LE_CABECA, S_LE_PROXIMO, S_AVALIA, S_MOVENDO, S_CHEGOU, S_PORTA
  } state_t;

  state_t           r_state, w_next;
  logic [3:0]       r_destino, r_proximo;
  logic             r_valido;
  logic [CNT_W-1:0] r_atendidos;
  logic [DW-1:0]    r_door;
  logic             w_arrive, w_abort, w_replan;
  logic [3:0]       w_move_addr;

  assign w_arrive = (r_destino == andar_atual);

`ifdef REPLAN_EN
  // While moving, the head is re-read every cycle so the target can follow it.
  assign w_move_addr = 4'd0;
  assign w_abort     = (q == 4'd0);
  assign w_replan    = (q != 4'd0) && (q != r_destino);
`else
  assign w_move_addr = 4'd1;
  assign w_abort     = 1'b0;
  assign w_replan    = 1'b0;
`endif

  always_ff @(posedge clk or posedge clear) begin
    if (clear) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:       if (enable) w_next = S_LE_CABECA;
      S_LE_CABECA:  w_next = S_LE_PROXIMO;
      S_LE_PROXIMO: w_next = S_AVALIA;
      S_AVALIA: begin
        if (r_destino == 4'd0) w_next = S_IDLE;
        else if (w_arrive)     w_next = S_CHEGOU;
        else                   w_next = S_MOVENDO;
      end
      S_MOVENDO: begin
        if (w_abort)       w_next = S_IDLE;
        else if (w_arrive) w_next = S_CHEGOU;
      end
      S_CHEGOU:     w_next = S_PORTA;
      S_PORTA:      if (r_door == '0) w_next = S_LE_CABECA;
      default:      w_next = S_IDLE;
    endcase
  end

  always_comb begin
    addr         = 4'd0;
    shift        = 1'b0;
    subir        = 1'b0;
    descer       = 1'b0;
    porta_aberta = 1'b0;
    unique case (r_state)
      S_LE_PROXIMO: addr = 4'd1;
      S_AVALIA:     addr = w_move_addr;
      S_MOVENDO: begin
        addr   = w_move_addr;
        subir  = !w_abort && (r_destino > andar_atual);
        descer = !w_abort && (r_destino < andar_atual);
      end
      S_CHEGOU:     shift = 1'b1;
      S_PORTA:      porta_aberta = 1'b1;
      default:      ;
    endcase
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_destino   <= 4'd0;
      r_proximo   <= 4'd0;
      r_valido    <= 1'b0;
      r_atendidos <= '0;
      r_door      <= '0;
    end else begin
      unique case (r_state)
        S_LE_PROXIMO: r_destino <= q;
        S_AVALIA: begin
          r_proximo <= q;
          if (r_destino == 4'd0) r_valido <= 1'b0;
          else if (!w_arrive)    r_valido <= 1'b1;
        end
        S_MOVENDO: begin
          if (w_abort)                    r_valido  <= 1'b0;
          else if (w_replan && !w_arrive) r_destino <= q;
        end
        S_CHEGOU: begin
          r_valido <= 1'b0;
          r_door   <= DOOR_LAST;
          if (r_atendidos != {CNT_W{1'b1}}) r_atendidos <= r_atendidos + CNT_W'(1);
        end
        S_PORTA: if (r_door != '0) r_door <= r_door - DW'(1);
        default: ;
      endcase
    end
  end

  assign destino        = r_destino;
  assign proximo        = r_proximo;
  assign destino_valido = r_valido;
  assign atendidos      = r_atendidos;

endmodule

// File: tb/tb_queue_stop_dispatcher.sv
// Randomized bench for queue_stop_dispatcher: queue RAM and car are modelled here,
// served stops are scored against the list of stops loaded into the queue.
module tb_queue_stop_dispatcher;

  localparam int DOOR  = 3;
  localparam int CNT_W = 2;
  localparam int MAXC  = 3;

  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic       enable = 1'b0;
  logic [3:0] andar_atual = 4'd1;
  logic [3:0] q = 4'd0;
  logic [3:0] addr, destino, proximo;
  logic       shift, destino_valido, subir, descer, porta_aberta;
  logic [CNT_W-1:0] atendidos;

  queue_stop_dispatcher #(.DOOR_CYCLES(DOOR), .CNT_W(CNT_W)) dut (
    .clk(clk), .clear(clear), .enable(enable), .andar_atual(andar_atual), .q(q),
    .addr(addr), .shift(shift), .destino(destino), .proximo(proximo),
    .destino_valido(destino_valido), .subir(subir), .descer(descer),
    .porta_aberta(porta_aberta), .atendidos(atendidos)
  );

  always #5 clk = ~clk;

  logic [31:0] outv;
  assign outv = 32'({addr, shift, destino, proximo, destino_valido, subir, descer,
                     porta_aberta, atendidos});

  logic [3:0] ram [16];
  int n_chk = 0, n_err = 0;
  int served, door_run, mcnt;
  bit prev_shift, sb_on, dv_seen, mot_seen;
  int exp_q[$];
  logic [3:0] sh_dest, sh_and;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: registered RAM read, pop on shift, car moves a floor every 2 commanded cycles.
  task automatic tick();
    logic [3:0] sa, sdst, sprx, sand;
    logic ss, su, sd;
    int e;
    sa = addr; ss = shift; su = subir; sd = descer;
    sdst = destino; sprx = proximo; sand = andar_atual;
    @(posedge clk); #1;
    q = ram[sa];
    if (ss) begin
      for (int i = 0; i < 15; i++) ram[i] = ram[i+1];
      ram[15] = 4'd0;
    end
    if (su || sd) begin
      mcnt++;
      if (mcnt == 2) begin
        mcnt = 0;
        if (su && andar_atual < 4'd15) andar_atual = andar_atual + 4'd1;
        if (sd && andar_atual > 4'd1)  andar_atual = andar_atual - 4'd1;
      end
    end else mcnt = 0;
    #1;
    if (ss) begin
      served++;
      sh_dest = sdst; sh_and = sand;
      chk("cnt", 32'(atendidos), 32'((served > MAXC) ? MAXC : served));
      chk("shift_w", 32'(prev_shift), 32'(0));
      if (sb_on) begin
        e = (exp_q.size() > 0) ? exp_q[0] : 0;
        chk("sb_dst", 32'(sdst), 32'(e));
        chk("sb_flr", 32'(sand), 32'(e));
        chk("sb_nxt", 32'(sprx), 32'((exp_q.size() > 1) ? exp_q[1] : 0));
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
    end
    prev_shift = ss;
    if (porta_aberta) begin
      door_run++;
      chk("door_motor", 32'({subir, descer}), 32'(0));
    end else if (door_run != 0) begin
      chk("door_len", 32'(door_run), 32'(DOOR));
      door_run = 0;
    end
    if (subir || descer)
      chk("dir", 32'({subir, descer}), 32'({destino > andar_atual, destino < andar_atual}));
    dv_seen  |= destino_valido;
    mot_seen |= (subir | descer);
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear = 1'b1; enable = 1'b0;
    #2;
    chk("rst_out", outv, 32'(0));
    @(negedge clk);
    clear = 1'b0; q = 4'd0;
    served = 0; door_run = 0; mcnt = 0; prev_shift = 0;
    dv_seen = 0; mot_seen = 0; sb_on = 0;
    exp_q.delete();
    for (int i = 0; i < 16; i++) ram[i] = 4'd0;
  endtask

  task automatic run_until(input int target, input int budget, input string tag);
    int k;
    k = 0;
    while (served < target && k < budget) begin tick(); k++; end
    chk(tag, 32'(served), 32'(target));
  endtask

  task automatic load(input int n, input logic [3:0] fl [8]);
    for (int i = 0; i < n; i++) begin ram[i] = fl[i]; exp_q.push_back(int'(fl[i])); end
  endtask

  logic [3:0] fl [8];
  int n;

  initial begin
    for (int i = 0; i < 16; i++) ram[i] = 4'd0;

    // enable low: nonempty queue is left alone
    do_reset();
    ram[0] = 4'd6; andar_atual = 4'd2;
    repeat (20) tick();
    chk("idle_shift", 32'(served), 32'(0));
    chk("idle_dv", 32'(dv_seen), 32'(0));

    // empty queue loops through the head reads without serving
    do_reset();
    enable = 1'b1;
    repeat (40) tick();
    chk("empty_shift", 32'(served), 32'(0));
    chk("empty_dv", 32'(dv_seen), 32'(0));

    // {5,9} from floor 2
    do_reset();
    fl[0] = 4'd5; fl[1] = 4'd9;
    load(2, fl); sb_on = 1; andar_atual = 4'd2; enable = 1'b1;
    repeat (5) tick();
    chk("t2_dv", 32'(destino_valido), 32'(1));
    chk("t2_up", 32'({subir, descer}), 32'(2));
    run_until(2, 200, "t2_served");
    repeat (10) tick();
    chk("t2_empty", 32'(exp_q.size()), 32'(0));
    chk("t2_dv_end", 32'(destino_valido), 32'(0));

    // head equals current floor: no motor at all
    do_reset();
    fl[0] = 4'd3;
    load(1, fl); sb_on = 1; andar_atual = 4'd3; enable = 1'b1;
    run_until(1, 50, "t3_served");
    chk("t3_motor", 32'(mot_seen), 32'(0));

    // clear in the middle of a move
    do_reset();
    ram[0] = 4'd7; andar_atual = 4'd2; enable = 1'b1;
    for (int k = 0; k < 20 && !subir; k++) tick();
    chk("t4_moving", 32'(subir), 32'(1));
    tick();
    clear = 1'b1;
    #1;
    chk("t4_clear", outv, 32'(0));
    chk("t4_noshift", 32'(ram[0]), 32'(7));
    chk("t4_served", 32'(served), 32'(0));

    // five stops with a 2-bit counter: saturation at 3
    do_reset();
    fl[0] = 4'd2; fl[1] = 4'd4; fl[2] = 4'd6; fl[3] = 4'd8; fl[4] = 4'd10;
    load(5, fl); sb_on = 1; andar_atual = 4'd1; enable = 1'b1;
    run_until(5, 500, "t5_served");
    chk("t5_sat", 32'(atendidos), 32'(MAXC));

    // head rewritten during a move
    do_reset();
    ram[0] = 4'd8; andar_atual = 4'd2; enable = 1'b1;
    for (int k = 0; k < 40 && andar_atual != 4'd3; k++) tick();
    ram[1] = ram[0]; ram[0] = 4'd4;
    tick(); tick();
`ifdef REPLAN_EN
    chk("t6_dst", 32'(destino), 32'(4));
    run_until(1, 200, "t6_served");
    chk("t6_stop", 32'(sh_and), 32'(4));
`else
    chk("t6_dst", 32'(destino), 32'(8));
    run_until(1, 200, "t6_served");
    chk("t6_stop", 32'(sh_and), 32'(8));
`endif

    // random queues from random start floors
    for (int r = 0; r < 8; r++) begin
      do_reset();
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) fl[i] = 4'($urandom_range(1, 15));
      load(n, fl); sb_on = 1;
      andar_atual = 4'($urandom_range(1, 15));
      enable = 1'b1;
      run_until(n, 120 * n, "rnd_served");
      repeat (20) tick();
      chk("rnd_extra", 32'(served), 32'(n));
      chk("rnd_left", 32'(exp_q.size()), 32'(0));
      chk("rnd_dv", 32'(destino_valido), 32'(0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
